// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader: state encoding,
// capacity and the big-endian byte-lane ordering used by both fetch and load.
package imem_pkg;

  localparam int IMEM_BYTES = 128;

  // Lane 0 is the most significant byte, stored at the lowest address.
  localparam logic [1:0] LANE_MSB = 2'd0;
  localparam logic [1:0] LANE_1   = 2'd1;
  localparam logic [1:0] LANE_2   = 2'd2;
  localparam logic [1:0] LANE_LSB = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    WRITE,
    DONE
  } loader_state_e;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    unique case (lane)
      LANE_MSB: b = word[31:24];
      LANE_1:   b = word[23:16];
      LANE_2:   b = word[15:8];
      default:  b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/instruction_memory_loader_serializer.sv
// Holds one instruction word and steps through its four bytes, MSB first.
module word_byte_serializer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] word_in,
  output logic        last_beat,
  output logic [7:0]  next_byte
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  // next_byte is the byte for the beat about to start, so the caller can register it.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load) begin
      word_d = word_in;
      idx_d  = LANE_MSB;
    end else if (advance) begin
      idx_d = idx_q + 2'd1;
    end
    next_byte = word_byte(word_d, idx_d);
    last_beat = (idx_q == LANE_LSB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= LANE_MSB;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Streams 32-bit instruction words into the byte-addressed instruction memory,
// four big-endian byte writes per word, after checking alignment and range.
module instruction_memory_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error
);

  loader_state_e    state_q, state_d;
  logic [31:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] words_left_q, words_left_d;
  logic             zero_pend_q, zero_pend_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             ser_load, ser_advance, ser_last;
  logic [7:0]       ser_next_byte;
  logic [32:0]      end_addr;
  logic             out_of_range;

  word_byte_serializer u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .advance   (ser_advance),
    .word_in   (in_word),
    .last_beat (ser_last),
    .next_byte (ser_next_byte)
  );

  assign end_addr     = {1'b0, base_addr} + 33'({num_words, 2'b00});
  assign out_of_range = (base_addr[1:0] != 2'b00) || (end_addr > 33'(MEM_BYTES));

  assign in_ready = (state_q == WAIT_WORD) ||
                    ((state_q == WRITE) && ser_last && (words_left_q > CNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    words_left_d = words_left_q;
    zero_pend_d  = zero_pend_q;
    ser_load     = 1'b0;
    ser_advance  = 1'b0;
    error_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (out_of_range) begin
            error_d = 1'b1;
          end else if (num_words == '0) begin
            state_d     = DONE;
            zero_pend_d = 1'b1;
          end else begin
            wr_ptr_d     = base_addr;
            words_left_d = num_words;
            state_d      = WAIT_WORD;
          end
        end
      end
      WAIT_WORD: begin
        if (in_valid) begin
          ser_load = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (!ser_last) begin
          ser_advance = 1'b1;
        end else begin
          words_left_d = words_left_q - CNT_W'(1);
          if (words_left_q == CNT_W'(1)) begin
            state_d = DONE;
          end else if (in_valid && in_ready) begin
            ser_load = 1'b1;
          end else begin
            state_d = WAIT_WORD;
          end
        end
      end
      DONE: begin
        // A zero-word load lingers one extra cycle so done lands two cycles after start.
        if (zero_pend_q) begin
          zero_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == WRITE) begin
      wr_ptr_d = wr_ptr_q + 32'd1;
    end

    mem_we_d    = (state_d == WRITE);
    mem_addr_d  = (state_d == WRITE) ? wr_ptr_q : mem_addr_q;
    mem_wdata_d = (state_d == WRITE) ? ser_next_byte : mem_wdata_q;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE) && !zero_pend_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      words_left_q <= '0;
      zero_pend_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      words_left_q <= words_left_d;
      zero_pend_q  <= zero_pend_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Write-side counterpart to the byte-addressed instruction memory. The loader takes 32-bit instruction words over a valid/ready stream and writes each word as four byte writes, big-endian: the most significant byte goes to the lowest address. Its output is a byte write port into the instruction memory's `mem` array. It sits between the boot/test program source and the instruction memory, and fills memory before the fetch path reads it.

## Interface
- `MEM_BYTES`, 128: byte capacity of the target memory.
- `CNT_W`, 8: width of the word-count input.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a load; sampled only in IDLE.
- `base_addr` in 32: first byte address of the load; sampled with `start`.
- `num_words` in CNT_W: number of 32-bit words to load; sampled with `start`.
- `in_valid` in 1: `in_word` holds a valid word.
- `in_ready` out 1: loader accepts `in_word` this cycle.
- `in_word` in 32: instruction word.
- `mem_we` out 1: byte write strobe.
- `mem_addr` out 32: byte address of the write.
- `mem_wdata` out 8: byte written.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a load completes.
- `error` out 1: one-cycle pulse when a `start` is rejected.

## Operation
- States:
  - IDLE
  - WAIT_WORD
  - WRITE, with a 2-bit `byte_idx`
  - DONE
- **IDLE**
  - `in_ready`=0.
  - On `start`:
    - If `base_addr[1:0]`≠0, or `base_addr + 4*num_words > MEM_BYTES`: pulse `error`, stay in IDLE, write nothing. The sum is computed 33 bits wide, so it cannot overflow.
    - Else if `num_words`==0: go to DONE.
    - Else: latch `wr_ptr`=`base_addr` and `words_left`=`num_words`, then go to WAIT_WORD.
- **WAIT_WORD**
  - `in_ready`=1.
  - On `in_valid`: latch the word, set `byte_idx`=0, go to WRITE.
- **WRITE**
  - Outputs: `mem_we`=1, `mem_addr`=`wr_ptr`.
  - `mem_wdata` = word[31:24], [23:16], [15:8], [7:0] for `byte_idx` 0..3.
  - `wr_ptr` increments by 1 each beat.
  - At `byte_idx`==3, `words_left` decrements. Then:
    - If the result is 0: go to DONE.
    - Else if `in_valid`&&`in_ready` this beat: latch the next word and stay in WRITE with `byte_idx`=0.
    - Else: go to WAIT_WORD.
  - `in_ready`=1 in WRITE only when `byte_idx`==3 and `words_left`>1. This gives back-to-back throughput of 4 cycles per word.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- `start` is ignored while `busy`=1.
- `in_word` is ignored whenever `in_ready`=0.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we`=0.
- Reset in any state forces IDLE on the next edge. The cycle after reset has `mem_we`=0, and a partially written word stays partial.

## Timing
- Reset values:
  - `in_ready`, `mem_we`, `busy`, `done`, `error` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0.
- All outputs are registered, except `in_ready`, which is decoded from the state registers only and never depends on `in_valid`.
- `start` in cycle T:
  - Accepted: `busy`=1 in T+1 and `in_ready`=1 in T+1.
  - Rejected: `error`=1 in T+1.
- Word accepted in cycle T: byte writes occur in T+1..T+4.
- Last byte written in cycle T: `done`=1 in T+1, `busy`=0 in T+2.
- An N-word load with an always-valid source: the last byte is written at T+1+4N, `done`=1 at T+2+4N, and `busy` is high from T+1 through T+2+4N.
- `num_words`=0: `done` in T+2, with no writes.

## Structure
- Shared package `imem_pkg`:
  - Loader state enum.
  - `IMEM_BYTES`=128.
  - Byte-lane selector constants (lane 0 = bits 31:24).
- The byte-serialization function is shared with the instruction memory's fetch ordering so both directions agree on endianness.
- One natural sub-module, `word_byte_serializer`: 32-bit holding register, 2-bit beat counter, byte mux, and last-beat flag. The FSM, address and range checks stay in the top module.

## Test plan
- `start`, `base_addr`=0, `num_words`=2, words 0x01020302 and 0xC0030002, source always valid → writes: addr 0..7 = 01,02,03,02,C0,03,00,02 on 8 consecutive cycles; `done` one cycle after the last byte; a byte-array model then reads back both words big-endian.
- `base_addr`=6 → `error` pulse, no `mem_we`, `busy` stays 0. `base_addr`=120, `num_words`=3 → `error`. `base_addr`=124, `num_words`=1 → accepted, writes addr 124..127.
- `num_words`=0 → `done` two cycles after `start`, no writes.
- Source drops `in_valid` for 5 cycles between words → loader waits in WAIT_WORD with `in_ready`=1 and `mem_we`=0; the second word is written intact afterwards.
- `start` asserted again while busy → ignored, and the original load completes unchanged. `reset` asserted after the 2nd byte of a word → the next cycle has `mem_we`=0, `busy`=0 and all outputs at their reset values; a fresh load then works.
